// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, op-select and sequencer state definitions
package cpu_pkg;

  localparam int OP_NOP = 0;
  localparam int OP_SHL = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_XOR = 4;
  localparam int OP_OR  = 5;
  localparam int OP_AND = 6;
  localparam int OP_SHR = 7;
  localparam int OP_NOT = 8;
  localparam int OP_MOV = 9;

  // Bit positions inside the one-hot op_sel bus
  localparam int SEL_SHL = 7;
  localparam int SEL_ADD = 6;
  localparam int SEL_SUB = 5;
  localparam int SEL_XOR = 4;
  localparam int SEL_OR  = 3;
  localparam int SEL_AND = 2;
  localparam int SEL_SHR = 1;
  localparam int SEL_NOT = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_WB   = 3'd2,
    ST_MOVE = 3'd3,
    ST_NULL = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_NULL = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_MOV  = 2'd2
  } op_class_t;

  function automatic logic [7:0] sel_onehot(input int idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - instruction handshake between decoder and sequencer
interface alu_seq_if #(
  parameter int NREG = 4,
  parameter int OPW  = 4
);
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_op;
  logic [SW-1:0]  instr_src;
  logic [SW-1:0]  instr_dst;

  modport master (
    output instr_valid, instr_op, instr_src, instr_dst,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_src, instr_dst,
    output instr_ready
  );
endinterface

// File: rtl/alu_seq_dec.sv
// rtl/alu_seq_dec.sv - combinational opcode decode into class, op_sel and illegal flag
module alu_seq_dec
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  output op_class_t      cls,
  output logic [7:0]     op_sel,
  output logic           illegal
);

  always_comb begin
    cls     = CLS_NULL;
    op_sel  = '0;
    illegal = 1'b0;
    case (int'(op))
      OP_NOP: cls = CLS_NULL;
      OP_SHL: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_SHL); end
      OP_ADD: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_ADD); end
      OP_SUB: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_SUB); end
      OP_XOR: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_XOR); end
      OP_OR:  begin cls = CLS_ALU; op_sel = sel_onehot(SEL_OR);  end
      OP_AND: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_AND); end
      OP_SHR: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_SHR); end
      OP_NOT: begin cls = CLS_ALU; op_sel = sel_onehot(SEL_NOT); end
      OP_MOV: cls = CLS_MOV;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - ALU control sequencer: FSM, instruction latch, register one-hot expansion
module alu_seq
  import cpu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_if.slave        instr,
  output logic            ialu,
  output logic            ealu,
  output logic [7:0]      op_sel,
  output logic [NREG-1:0] src_en,
  output logic [NREG-1:0] dst_ld,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t          state, state_nxt;
  op_class_t       in_cls;
  logic [7:0]      in_sel;
  logic            in_ill;
  logic [7:0]      sel_q;
  logic            ill_q;
  logic [SW-1:0]   src_q, dst_q;
  logic [NREG-1:0] src_oh, dst_oh;
  logic            ready;
  logic            accept;

  alu_seq_dec #(.OPW(OPW)) u_dec (
    .op      (instr.instr_op),
    .cls     (in_cls),
    .op_sel  (in_sel),
    .illegal (in_ill)
  );

  assign ready             = (state == ST_IDLE);
  assign instr.instr_ready = ready;
  assign accept            = instr.instr_valid && ready;

  // Decoded fields are latched so outputs depend only on registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      ill_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
    end else if (accept) begin
      sel_q <= in_sel;
      ill_q <= in_ill;
      src_q <= instr.instr_src;
      dst_q <= instr.instr_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (in_cls)
            CLS_ALU: state_nxt = ST_EXEC;
            CLS_MOV: state_nxt = ST_MOVE;
            default: state_nxt = ST_NULL;
          endcase
        end
      end
      ST_EXEC: state_nxt = ST_WB;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign src_oh = NREG'(1) << src_q;
  assign dst_oh = NREG'(1) << dst_q;

  // Only EXEC and MOVE drive a register onto the bus, only WB drives the ALU
  always_comb begin
    ialu   = 1'b0;
    ealu   = 1'b0;
    op_sel = '0;
    src_en = '0;
    dst_ld = '0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (state != ST_IDLE);
    case (state)
      ST_EXEC: begin
        ialu   = 1'b1;
        op_sel = sel_q;
        src_en = sel_q[SEL_NOT] ? '0 : src_oh;
      end
      ST_WB: begin
        ealu   = 1'b1;
        dst_ld = dst_oh;
        done   = 1'b1;
      end
      ST_MOVE: begin
        src_en = src_oh;
        dst_ld = dst_oh;
        done   = 1'b1;
      end
      ST_NULL: begin
        done = 1'b1;
        err  = ill_q;
      end
      default: ;
    endcase
  end

endmodule
